mips_mc_control: RTL and testbench



---
 rtl/mips_mc_control.sv | 195 +++++++++++++++++++
 tb/tb_mips_mc_control.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/mips_mc_control.sv
// mips_mc_control: multi-cycle main control FSM for the MIPS core.
// Sequences a shared ALU and a unified memory port through fetch, decode,
// execute, memory and writeback. All datapath selects and strobes are Moore
// decodes of the current state, except ir_write/pc_write in FETCH, which are
// qualified by mem_ready so the IR and PC only load when the fetch completes.
//
// Ports:
//   clk, reset_n      clock (rising edge), asynchronous active-low reset
//   opcode[5:0]       IR[31:26], sampled only in DECODE and MEMADR
//   mem_ready         memory access completes this cycle
//   pc_write ... pc_source   datapath strobes and mux selects
//   state[3:0]        current state code (debug/verification)
//   illegal           sticky flag, unsupported opcode decoded
//   retired[CNT_W-1:0] retired-instruction count, wraps
//
// Memory handshake: mem_read/mem_write are asserted for the whole time the
// FSM sits in FETCH, MEMRD or MEMWR and only drop after the cycle in which
// mem_ready is sampled 1; mem_ready is ignored in every other state.
module mips_mc_control #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [5:0]       opcode,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             iord,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             mem_to_reg,
    output logic             reg_dst,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       pc_source,
    output logic [3:0]       state,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_REX    = 4'd7,
        S_RWB    = 4'd8,
        S_BEQ    = 4'd9,
        S_JUMP   = 4'd10,
        S_AEX    = 4'd11,
        S_AWB    = 4'd12,
        S_HALT   = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    state_t state_q, state_d;
    logic   retire;
    logic   illegal_q;
    logic [CNT_W-1:0] retired_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            illegal_q <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_d == S_HALT)
                illegal_q <= 1'b1;
            if (retire)
                retired_q <= retired_q + 1'b1;
        end
    end

    always_comb begin
        state_d       = state_q;
        retire        = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        pc_source     = 2'b00;

        unique case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                // PC+4 computed while the instruction is read.
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                // Branch target precompute into ALUOut.
                alu_src_b = 2'b11;
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_REX;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_AEX;
                    default:      state_d = S_HALT;
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                retire     = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
                if (mem_ready) begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_REX: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
                state_d   = S_RWB;
            end
            S_RWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            S_BEQ: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'b01;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
                retire        = 1'b1;
                state_d       = S_FETCH;
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = 2'b10;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            S_AEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = S_AWB;
            end
            S_AWB: begin
                reg_write = 1'b1;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            S_HALT: state_d = S_HALT;
            // Unused encodings recover through IDLE.
            default: state_d = S_IDLE;
        endcase
    end

    assign state   = state_q;
    assign illegal = illegal_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_mips_mc_control.sv
// Testbench for mips_mc_control (CNT_W=4 so counter wrap is reachable).
module tb_mips_mc_control;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       illegal;
    } ctl_t;

    localparam int W = 4 + $bits(ctl_t) + 4;

    localparam ctl_t C_IDLE    = '0;
    localparam ctl_t C_FETCH_W = '{mem_read:1'b1, alu_src_b:2'b01, default:'0};
    localparam ctl_t C_FETCH_G = '{pc_write:1'b1, mem_read:1'b1, ir_write:1'b1,
                                   alu_src_b:2'b01, default:'0};
    localparam ctl_t C_DECODE  = '{alu_src_b:2'b11, default:'0};
    localparam ctl_t C_MEMADR  = '{alu_src_a:1'b1, alu_src_b:2'b10, default:'0};
    localparam ctl_t C_MEMRD   = '{iord:1'b1, mem_read:1'b1, default:'0};
    localparam ctl_t C_MEMWB   = '{mem_to_reg:1'b1, reg_write:1'b1, default:'0};
    localparam ctl_t C_MEMWR   = '{iord:1'b1, mem_write:1'b1, default:'0};
    localparam ctl_t C_REX     = '{alu_src_a:1'b1, alu_op:2'b10, default:'0};
    localparam ctl_t C_RWB     = '{reg_dst:1'b1, reg_write:1'b1, default:'0};
    localparam ctl_t C_BEQ     = '{pc_write_cond:1'b1, alu_src_a:1'b1, alu_op:2'b01,
                                   pc_source:2'b01, default:'0};
    localparam ctl_t C_JUMP    = '{pc_write:1'b1, pc_source:2'b10, default:'0};
    localparam ctl_t C_AEX     = '{alu_src_a:1'b1, alu_src_b:2'b10, default:'0};
    localparam ctl_t C_AWB     = '{reg_write:1'b1, default:'0};
    localparam ctl_t C_HALT    = '{illegal:1'b1, default:'0};

    // mr: 0/1 drive that value, 2 = random (mem_ready is a don't-care there)
    typedef struct {
        logic [5:0] op;
        logic [1:0] mr;
        logic [3:0] st;
        ctl_t       ctl;
    } vec_t;

    logic       clk;
    logic       reset_n;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic [3:0] state;
    logic       illegal;
    logic [3:0] retired;

    mips_mc_control #(.CNT_W(4)) dut (
        .clk(clk), .reset_n(reset_n), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .iord(iord),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_source(pc_source), .state(state), .illegal(illegal), .retired(retired)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    ctl_t dut_ctl;
    assign dut_ctl = {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
                      mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
                      pc_source, illegal};

    // scoreboard
    logic [W-1:0] exp_q[$];
    logic [3:0]   exp_ret;
    int           checks = 0;
    int           errors = 0;
    vec_t         vq[$];

    task automatic compare_now(input string name);
        logic [W-1:0] exp, got;
        got = {state, dut_ctl, retired};
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty, got %h", name, got);
            return;
        end
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got state=%0d ctl=%h retired=%h, expected state=%0d ctl=%h retired=%h",
                     name, got[W-1 -: 4], got[W-5 -: $bits(ctl_t)], got[3:0],
                     exp[W-1 -: 4], exp[W-5 -: $bits(ctl_t)], exp[3:0]);
        end
    endtask

    // driver: called at posedge+1, checks the cycle at the negedge
    task automatic step(input logic [5:0] op, input logic [1:0] mr,
                        input logic [3:0] es, input ctl_t ec, input string name);
        opcode    = op;
        mem_ready = (mr == 2'd2) ? 1'($urandom_range(0, 1)) : mr[0];
        exp_q.push_back({es, ec, exp_ret});
        @(negedge clk);
        compare_now(name);
        if (es inside {4'd5, 4'd8, 4'd9, 4'd10, 4'd12} || (es == 4'd6 && mem_ready))
            exp_ret = exp_ret + 4'd1;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        exp_ret = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        exp_q.push_back({4'd0, C_IDLE, 4'd0});
        compare_now("reset");
        reset_n = 1'b1;
    endtask

    task automatic add(input logic [5:0] op, input logic [1:0] mr,
                       input logic [3:0] st, input ctl_t ctl);
        vec_t v;
        v.op = op; v.mr = mr; v.st = st; v.ctl = ctl;
        vq.push_back(v);
    endtask

    initial begin
        reset_n   = 1'b0;
        opcode    = 6'h00;
        mem_ready = 1'b0;
        exp_ret   = 4'd0;

        // R-type, lw with waits, beq, j, addi, sw with a wait, illegal
        add(6'h00, 2, 0,  C_IDLE);
        add(6'h00, 1, 1,  C_FETCH_G);
        add(6'h00, 2, 2,  C_DECODE);
        add(6'h00, 2, 7,  C_REX);
        add(6'h00, 2, 8,  C_RWB);
        add(6'h23, 0, 1,  C_FETCH_W);
        add(6'h23, 1, 1,  C_FETCH_G);
        add(6'h23, 2, 2,  C_DECODE);
        add(6'h23, 2, 3,  C_MEMADR);
        add(6'h23, 0, 4,  C_MEMRD);
        add(6'h23, 0, 4,  C_MEMRD);
        add(6'h23, 0, 4,  C_MEMRD);
        add(6'h23, 1, 4,  C_MEMRD);
        add(6'h23, 2, 5,  C_MEMWB);
        add(6'h04, 1, 1,  C_FETCH_G);
        add(6'h04, 2, 2,  C_DECODE);
        add(6'h04, 2, 9,  C_BEQ);
        add(6'h02, 1, 1,  C_FETCH_G);
        add(6'h02, 2, 2,  C_DECODE);
        add(6'h02, 2, 10, C_JUMP);
        add(6'h08, 1, 1,  C_FETCH_G);
        add(6'h08, 2, 2,  C_DECODE);
        add(6'h08, 2, 11, C_AEX);
        add(6'h08, 2, 12, C_AWB);
        add(6'h2B, 1, 1,  C_FETCH_G);
        add(6'h2B, 2, 2,  C_DECODE);
        add(6'h2B, 2, 3,  C_MEMADR);
        add(6'h2B, 0, 6,  C_MEMWR);
        add(6'h2B, 1, 6,  C_MEMWR);
        add(6'h3F, 1, 1,  C_FETCH_G);
        add(6'h3F, 2, 2,  C_DECODE);

        do_reset();
        foreach (vq[i]) step(vq[i].op, vq[i].mr, vq[i].st, vq[i].ctl, "tbl");

        // HALT is absorbing: no strobes, retired frozen whatever the inputs
        for (int i = 0; i < 20; i++)
            step(6'($urandom_range(0, 63)), 2, 4'd15, C_HALT, "halt");

        // reset clears illegal and restarts from IDLE
        do_reset();
        step(6'h00, 2, 0, C_IDLE, "illegal_clr");
        step(6'h00, 1, 1, C_FETCH_G, "illegal_clr");
        step(6'h00, 2, 2, C_DECODE, "illegal_clr");
        step(6'h00, 2, 7, C_REX, "illegal_clr");
        step(6'h00, 2, 8, C_RWB, "illegal_clr");

        // sw stalled in MEMWR, then reset asserted mid-cycle
        step(6'h2B, 1, 1, C_FETCH_G, "sw_rst");
        step(6'h2B, 2, 2, C_DECODE, "sw_rst");
        step(6'h2B, 2, 3, C_MEMADR, "sw_rst");
        step(6'h2B, 0, 6, C_MEMWR, "sw_rst");
        step(6'h2B, 0, 6, C_MEMWR, "sw_rst");
        #2;
        reset_n = 1'b0;
        exp_ret = 4'd0;
        #1;
        exp_q.push_back({4'd0, C_IDLE, 4'd0});
        compare_now("sw_async_rst");
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        step(6'h2B, 1, 0, C_IDLE, "sw_rst_release");
        step(6'h2B, 0, 1, C_FETCH_W, "sw_rst_release");

        // counter wrap: 17 back-to-back jumps with a 4-bit counter
        do_reset();
        step(6'h02, 2, 0, C_IDLE, "wrap");
        for (int n = 0; n < 17; n++) begin
            step(6'h02, 1, 1,  C_FETCH_G, "wrap");
            step(6'h02, 2, 2,  C_DECODE, "wrap");
            step(6'h02, 2, 10, C_JUMP, "wrap");
        end
        step(6'h02, 0, 1, C_FETCH_W, "wrap_final");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
